// File: rtl/gcm_pkg.sv
// rtl/gcm_pkg.sv - shared GCM constants, FSM state type and GF(2^128) shift helper
package gcm_pkg;

  localparam int GCM_BLK_W  = 128;
  localparam int GF_MUL_LAT = 129;

  // Reduction constant R = 11100001 || 0^120, in GCM bit order
  localparam logic [0:GCM_BLK_W-1] GF_R = {8'hE1, 120'h0};

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    MUL,
    LEN,
    DONE
  } state_e;

  // V * x in GCM bit order: shift toward index 127, reduce if bit 127 falls out
  function automatic logic [0:GCM_BLK_W-1] gf_mulx(input logic [0:GCM_BLK_W-1] v);
    return v[GCM_BLK_W-1] ? ((v >> 1) ^ GF_R) : (v >> 1);
  endfunction

endpackage

// File: rtl/gfmul_v2.sv
// rtl/gfmul_v2.sv - bit-serial GF(2^128) multiplier, one operand bit per cycle
module gfmul_v2
  import gcm_pkg::*;
(
  input  logic                 iClk,
  input  logic                 iRstn,
  input  logic [0:GCM_BLK_W-1] iCtext,
  input  logic                 iCtext_valid,
  input  logic [0:GCM_BLK_W-1] iHashkey,
  input  logic                 iHashkey_valid,
  output logic [0:GCM_BLK_W-1] oResult,
  output logic                 oResult_valid
);

  logic [7:0]           r_cnt;
  logic [0:GCM_BLK_W-1] r_z;
  logic [0:GCM_BLK_W-1] r_v;
  logic                 w_go;
  logic                 w_done;
  logic [0:GCM_BLK_W-1] w_z_cur;
  logic [0:GCM_BLK_W-1] w_v_cur;
  logic [0:GCM_BLK_W-1] w_z_nxt;

  assign w_go   = iCtext_valid & iHashkey_valid;
  assign w_done = w_go && (r_cnt == 8'(GF_MUL_LAT - 1));

  // Step 0 seeds the accumulators directly, so back-to-back products need no idle cycle
  always_comb begin
    w_z_cur = (r_cnt == 8'd0) ? '0 : r_z;
    w_v_cur = (r_cnt == 8'd0) ? iHashkey : r_v;
    w_z_nxt = iCtext[r_cnt[6:0]] ? (w_z_cur ^ w_v_cur) : w_z_cur;
  end

  always_ff @(posedge iClk) begin
    if (!iRstn) begin
      r_cnt <= 8'd0;
      r_z   <= '0;
      r_v   <= '0;
    end else if (!w_go || w_done) begin
      r_cnt <= 8'd0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
      r_z   <= w_z_nxt;
      r_v   <= gf_mulx(w_v_cur);
    end
  end

  assign oResult       = r_z;
  assign oResult_valid = w_done;

endmodule

// File: rtl/ghash_core.sv
// rtl/ghash_core.sv - GHASH accumulator: folds data blocks then the length block through one multiplier
module ghash_core
  import gcm_pkg::*;
(
  input  logic                 iClk,
  input  logic                 iRstn,
  input  logic [0:GCM_BLK_W-1] iHashkey,
  input  logic                 iHashkey_valid,
  input  logic                 iStart,
  input  logic [0:63]          iAadBits,
  input  logic [0:63]          iCtBits,
  input  logic [0:GCM_BLK_W-1] iBlock,
  input  logic                 iBlock_valid,
  input  logic                 iBlock_last,
  output logic                 oBlock_ready,
  output logic [0:GCM_BLK_W-1] oGhash,
  output logic                 oGhash_valid,
  output logic                 oBusy
);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [0:GCM_BLK_W-1] r_y;
  logic [0:GCM_BLK_W-1] r_op;
  logic [0:GCM_BLK_W-1] r_lenblk;
  logic [0:GCM_BLK_W-1] r_ghash;
  logic                 r_last;
  logic                 r_mul_go;
  logic [0:GCM_BLK_W-1] w_result;
  logic                 w_result_valid;
  logic                 w_start_ok;

  assign w_start_ok = iStart & iHashkey_valid;

  always_comb begin
    w_state_nxt  = r_state;
    oBlock_ready = 1'b0;
    oGhash_valid = 1'b0;
    oBusy        = (r_state != IDLE);
    case (r_state)
      IDLE: if (w_start_ok)
              w_state_nxt = (iAadBits == 64'd0 && iCtBits == 64'd0) ? LEN : WAIT;
      WAIT: begin
        oBlock_ready = 1'b1;
        if (iBlock_valid) w_state_nxt = MUL;
      end
      MUL:  if (w_result_valid) w_state_nxt = r_last ? LEN : WAIT;
      LEN:  if (w_result_valid) w_state_nxt = DONE;
      DONE: begin
        oGhash_valid = 1'b1;
        w_state_nxt  = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRstn) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge iClk) begin
    if (!iRstn) begin
      r_y      <= '0;
      r_op     <= '0;
      r_lenblk <= '0;
      r_ghash  <= '0;
      r_last   <= 1'b0;
      r_mul_go <= 1'b0;
    end else begin
      // Follows the next state so the multiplier stays driven straight from MUL into LEN
      r_mul_go <= (w_state_nxt == MUL) || (w_state_nxt == LEN);
      case (r_state)
        IDLE: if (w_start_ok) begin
          r_y      <= '0;
          r_lenblk <= {iAadBits, iCtBits};
          r_op     <= {iAadBits, iCtBits};
        end
        WAIT: if (iBlock_valid) begin
          r_op   <= r_y ^ iBlock;
          r_last <= iBlock_last;
        end
        MUL: if (w_result_valid) begin
          r_y <= w_result;
          if (r_last) r_op <= w_result ^ r_lenblk;
        end
        LEN: if (w_result_valid) r_ghash <= w_result;
        default: ;
      endcase
    end
  end

  gfmul_v2 u_gfmul (
    .iClk           (iClk),
    .iRstn          (iRstn),
    .iCtext         (r_op),
    .iCtext_valid   (r_mul_go),
    .iHashkey       (iHashkey),
    .iHashkey_valid (r_mul_go),
    .oResult        (w_result),
    .oResult_valid  (w_result_valid)
  );

  assign oGhash = r_ghash;

endmodule
